// File: rtl/multdiv_issue_ctrl_pkg.sv
// Shared types and constants for the multdiv issue controller.
// The exception status codes are used when MULTDIV_RSTATUS_EN is defined.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    localparam int RSTATUS_REG  = 30;
    localparam int RSTATUS_MULT = 4;
    localparam int RSTATUS_DIV  = 5;

    function automatic int rstatus_code(op_t op);
        return (op == OP_MULT) ? RSTATUS_MULT : RSTATUS_DIV;
    endfunction

endpackage

// File: rtl/multdiv_issue_ctrl_if.sv
// Bundle of execute-side request, multdiv handshake and writeback signals.
// The slave modport is the controller view; the master modport is the surrounding pipeline/multdiv.
interface multdiv_issue_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
);
    logic             ex_is_mult;
    logic             ex_is_div;
    logic [REGW-1:0]  ex_rd;
    logic [WIDTH-1:0] ex_opA;
    logic [WIDTH-1:0] ex_opB;

    logic [WIDTH-1:0] md_operandA;
    logic [WIDTH-1:0] md_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] md_result;
    logic             md_exception;
    logic             md_resultRDY;

    logic             stall;
    logic             wb_valid;
    logic [REGW-1:0]  wb_rd;
    logic [WIDTH-1:0] wb_data;
    logic             wb_exception;

    modport slave (
        input  ex_is_mult, ex_is_div, ex_rd, ex_opA, ex_opB,
        input  md_result, md_exception, md_resultRDY,
        output md_operandA, md_operandB, ctrl_MULT, ctrl_DIV,
        output stall, wb_valid, wb_rd, wb_data, wb_exception
    );

    modport master (
        output ex_is_mult, ex_is_div, ex_rd, ex_opA, ex_opB,
        output md_result, md_exception, md_resultRDY,
        input  md_operandA, md_operandB, ctrl_MULT, ctrl_DIV,
        input  stall, wb_valid, wb_rd, wb_data, wb_exception
    );

endinterface

// File: rtl/multdiv_issue_ctrl_watchdog.sv
// Saturating cycle counter that flags when TIMEOUT cycles have elapsed since the last clear.
module md_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != CW'(TIMEOUT))) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(TIMEOUT));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller for the iterative multdiv unit: latches an op, pulses start, stalls, writes back once.
// Optional feature macro: MULTDIV_RSTATUS_EN (exceptions write a status code to the status register).
module multdiv_issue_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int REGW    = 5,
    parameter int TIMEOUT = 64
) (
    input  logic                 clock,
    input  logic                 reset_n,
    multdiv_issue_ctrl_if.slave  bus
);

    state_t           state;
    state_t           next_state;
    op_t              op_q;
    logic [REGW-1:0]  rd_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] res_data;
    logic             res_exc;
    logic             accept;
    logic             wd_clear;
    logic             wd_enable;
    logic             wd_expired;

    // A new op is taken only from IDLE; a request seen during WB is the retiring op.
    assign accept    = (state == IDLE) && (bus.ex_is_mult || bus.ex_is_div);
    assign wd_clear  = (state == ISSUE);
    assign wd_enable = (state == WAIT);

    md_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (bus.md_resultRDY || wd_expired) next_state = WB;
            WB:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand/destination capture on accept; multdiv sees these from ISSUE through WAIT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q  <= OP_MULT;
            rd_q  <= '0;
            opa_q <= '0;
            opb_q <= '0;
        end else if (accept) begin
            op_q  <= bus.ex_is_mult ? OP_MULT : OP_DIV;
            rd_q  <= bus.ex_rd;
            opa_q <= bus.ex_opA;
            opb_q <= bus.ex_opB;
        end
    end

    // Result capture: a real RDY takes priority over a watchdog expiring in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            res_data <= '0;
            res_exc  <= 1'b0;
        end else if (state == WAIT) begin
            if (bus.md_resultRDY) begin
                res_data <= bus.md_result;
                res_exc  <= bus.md_exception;
            end else if (wd_expired) begin
                res_data <= '0;
                res_exc  <= 1'b1;
            end
        end
    end

    assign bus.md_operandA = opa_q;
    assign bus.md_operandB = opb_q;
    assign bus.ctrl_MULT   = (state == ISSUE) && (op_q == OP_MULT);
    assign bus.ctrl_DIV    = (state == ISSUE) && (op_q == OP_DIV);
    assign bus.stall       = reset_n && ((state == ISSUE) || (state == WAIT) || accept);

    always_comb begin
        bus.wb_valid     = 1'b0;
        bus.wb_rd        = '0;
        bus.wb_data      = '0;
        bus.wb_exception = 1'b0;
        if (state == WB) begin
            bus.wb_exception = res_exc;
`ifdef MULTDIV_RSTATUS_EN
            if (res_exc) begin
                bus.wb_valid = 1'b1;
                bus.wb_rd    = REGW'(RSTATUS_REG);
                bus.wb_data  = WIDTH'(rstatus_code(op_q));
            end else begin
                bus.wb_valid = (rd_q != '0);
                bus.wb_rd    = rd_q;
                bus.wb_data  = res_data;
            end
`else
            bus.wb_valid = (rd_q != '0);
            bus.wb_rd    = rd_q;
            bus.wb_data  = res_data;
`endif
        end
    end

endmodule
